stream_demux_1_4: RTL and testbench

- Single-input, four-output stream demultiplexer. Each word carries a 2-bit destination select.
- Each accepted word is steered into a one-entry register slot for its output channel and presented there with valid/ready flow control.
- It is the counterpart of the 4:1 datapath mux: it fans one producer out to four consumers, where the mux fans four sources into one.
- Each channel has a wrapping 8-bit accepted-word counter for debug and scoreboarding.

---
 rtl/stream_demux_1_4_pkg.sv | 12 +
 rtl/stream_demux_1_4_if.sv | 32 +++
 rtl/stream_demux_1_4_slot.sv | 56 +++++
 rtl/stream_demux_1_4.sv | 69 ++++++
 tb/tb_stream_demux_1_4.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/stream_demux_1_4_pkg.sv
// Shared constants and types for the 1:4 stream demultiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stream_demux_pkg;

   localparam int N_CH      = 4;   // number of output channels
   localparam int DEF_W     = 4;   // default payload width
   localparam int DEF_CNT_W = 8;   // default per-channel transfer counter width

   typedef logic [1:0] ch_sel_t;

endpackage

// File: rtl/stream_demux_1_4_if.sv
// Handshake bundle between one producer and four consumers of the demux.
// Latency: n/a (wiring only).
// Backpressure: carries in_valid/in_ready and per-channel out_valid/out_ready.
// Ports: master = producer/consumer side, slave = demux side.
interface stream_demux_1_4_if
   import stream_demux_pkg::*;
#(
   parameter int W = DEF_W
);

   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    in_data;
   ch_sel_t         in_sel;
   logic [N_CH-1:0] out_valid;
   logic [N_CH-1:0] out_ready;
   logic [W-1:0]    out_data0;
   logic [W-1:0]    out_data1;
   logic [W-1:0]    out_data2;
   logic [W-1:0]    out_data3;

   modport master (
      output in_valid, in_data, in_sel, out_ready,
      input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
   );

   modport slave (
      input  in_valid, in_data, in_sel, out_ready,
      output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
   );

endinterface

// File: rtl/stream_demux_1_4_slot.sv
// One-entry register slot with an accepted-word counter (one per demux channel).
// Latency: a load at an edge is visible on full/data/cnt right after that edge.
// Backpressure: caller only loads when empty or draining; load wins over drain.
// Ports: clk, rst_n, load/load_data (input side), drain (output side), full, data, cnt.
module demux_slot
   import stream_demux_pkg::*;
#(
   parameter int W     = DEF_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [W-1:0]     load_data,
   input  logic             drain,
   output logic             full,
   output logic [W-1:0]     data,
   output logic [CNT_W-1:0] cnt
);

   logic             full_q, full_d;
   logic [W-1:0]     data_q, data_d;
   logic [CNT_W-1:0] cnt_q,  cnt_d;

   // A load in the same cycle as a drain replaces the departing word, so the
   // slot stays full with no bubble. A drain alone keeps the stale data.
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      cnt_d  = cnt_q;
      if (load) begin
         full_d = 1'b1;
         data_d = load_data;
         cnt_d  = cnt_q + CNT_W'(1);
      end else if (drain) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

   assign full = full_q;
   assign data = data_q;
   assign cnt  = cnt_q;

endmodule

// File: rtl/stream_demux_1_4.sv
// 1:4 stream demultiplexer: each word is steered by in_sel into a per-channel register slot.
// Latency: one cycle, word visible on its channel right after the accepting edge; 1 word/cycle.
// Backpressure: in_ready stalls only when the selected slot is full and its consumer is not ready.
// Ports: clk, rst_n, bus (slave modport: input stream + four output streams), xfer_cnt0..3.
module stream_demux_1_4
   import stream_demux_pkg::*;
#(
   parameter int W     = DEF_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   stream_demux_1_4_if.slave    bus,
   output logic [CNT_W-1:0]     xfer_cnt0,
   output logic [CNT_W-1:0]     xfer_cnt1,
   output logic [CNT_W-1:0]     xfer_cnt2,
   output logic [CNT_W-1:0]     xfer_cnt3
);

   logic [N_CH-1:0]  full;
   logic [N_CH-1:0]  load;
   logic [N_CH-1:0]  drain;
   logic             in_ready_w;
   logic [W-1:0]     data [N_CH];
   logic [CNT_W-1:0] cnt  [N_CH];

   // Only path from inputs to outputs that is combinational: out_ready/in_sel -> in_ready.
   // Computed regardless of in_valid so a producer can probe before committing.
   assign in_ready_w   = !full[bus.in_sel] | bus.out_ready[bus.in_sel];
   assign bus.in_ready = in_ready_w;

   assign drain = full & bus.out_ready;

   // One-hot load enable: an input transfer touches only the selected channel.
   always_comb begin
      load = '0;
      if (bus.in_valid && in_ready_w) begin
         load[bus.in_sel] = 1'b1;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_slot
      demux_slot #(
         .W     (W),
         .CNT_W (CNT_W)
      ) u_slot (
         .clk       (clk),
         .rst_n     (rst_n),
         .load      (load[i]),
         .load_data (bus.in_data),
         .drain     (drain[i]),
         .full      (full[i]),
         .data      (data[i]),
         .cnt       (cnt[i])
      );
   end

   assign bus.out_valid = full;
   assign bus.out_data0 = data[0];
   assign bus.out_data1 = data[1];
   assign bus.out_data2 = data[2];
   assign bus.out_data3 = data[3];

   assign xfer_cnt0 = cnt[0];
   assign xfer_cnt1 = cnt[1];
   assign xfer_cnt2 = cnt[2];
   assign xfer_cnt3 = cnt[3];

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Self-checking bench for stream_demux_1_4: scoreboard queues per channel, directed steps.
module tb_stream_demux_1_4;
   import stream_demux_pkg::*;

   localparam int W     = 4;
   localparam int CNT_W = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   stream_demux_1_4_if #(.W(W)) bus ();
   logic [CNT_W-1:0] xfer_cnt0, xfer_cnt1, xfer_cnt2, xfer_cnt3;

   stream_demux_1_4 #(.W(W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .xfer_cnt0 (xfer_cnt0),
      .xfer_cnt1 (xfer_cnt1),
      .xfer_cnt2 (xfer_cnt2),
      .xfer_cnt3 (xfer_cnt3)
   );

   logic [W-1:0]     sb      [N_CH][$];
   logic [CNT_W-1:0] exp_cnt [N_CH];
   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] od(input int i);
      case (i)
         0:       return bus.out_data0;
         1:       return bus.out_data1;
         2:       return bus.out_data2;
         default: return bus.out_data3;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] oc(input int i);
      case (i)
         0:       return xfer_cnt0;
         1:       return xfer_cnt1;
         2:       return xfer_cnt2;
         default: return xfer_cnt3;
      endcase
   endfunction

   task automatic model_clear();
      for (int i = 0; i < N_CH; i++) begin
         sb[i].delete();
         exp_cnt[i] = '0;
      end
   endtask

   task automatic drive(input logic v, input ch_sel_t s, input logic [W-1:0] d, input logic [3:0] r);
      bus.in_valid  = v;
      bus.in_sel    = s;
      bus.in_data   = d;
      bus.out_ready = r;
   endtask

   // One clock: check outputs and in_ready at the falling edge against the
   // scoreboard, update the model for the coming rising edge, then step past it.
   task automatic cycle();
      ch_sel_t s;
      logic    exp_rdy;
      @(negedge clk);
      for (int i = 0; i < N_CH; i++) begin
         chk($sformatf("out_valid%0d", i), 32'(bus.out_valid[i]), 32'(sb[i].size() != 0));
         if (sb[i].size() != 0) chk($sformatf("out_data%0d", i), 32'(od(i)), 32'(sb[i][0]));
         chk($sformatf("xfer_cnt%0d", i), 32'(oc(i)), 32'(exp_cnt[i]));
      end
      s       = bus.in_sel;
      exp_rdy = (sb[s].size() == 0) || bus.out_ready[s];
      chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      for (int i = 0; i < N_CH; i++) begin
         if (sb[i].size() != 0 && bus.out_ready[i]) void'(sb[i].pop_front());
      end
      if (bus.in_valid && exp_rdy) begin
         sb[s].push_back(bus.in_data);
         exp_cnt[s] = exp_cnt[s] + 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      model_clear();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      model_clear();
      drive(1'b0, 2'd0, '0, 4'b0000);
      #2;
      // Reset state
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_in_ready",  32'(bus.in_ready), 32'h1);
      for (int i = 0; i < N_CH; i++) begin
         chk($sformatf("rst_data%0d", i), 32'(od(i)), 32'h0);
         chk($sformatf("rst_cnt%0d", i),  32'(oc(i)), 32'h0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Basic route to channel 1
      drive(1'b1, 2'd1, 4'h5, 4'b0000);
      cycle();
      chk("basic_out_valid", 32'(bus.out_valid), 32'b0010);
      chk("basic_data1",     32'(bus.out_data1), 32'h5);
      chk("basic_cnt1",      32'(xfer_cnt1),     32'h1);
      drive(1'b1, 2'd1, 4'h6, 4'b0000);
      #1;
      chk("basic_blocked", 32'(bus.in_ready), 32'h0);
      cycle();
      drive(1'b0, 2'd0, 4'h0, 4'b1111);
      cycle();

      // Backpressure isolation: channel 3 stuck full
      drive(1'b1, 2'd3, 4'hC, 4'b0000);
      cycle();
      drive(1'b1, 2'd3, 4'hD, 4'b0001);
      #1;
      chk("bp_ch3_blocked", 32'(bus.in_ready), 32'h0);
      cycle();
      drive(1'b1, 2'd0, 4'h1, 4'b0001);
      #1;
      chk("bp_ch0_rdy_a", 32'(bus.in_ready), 32'h1);
      cycle();
      drive(1'b1, 2'd0, 4'h2, 4'b0001);
      #1;
      chk("bp_ch0_rdy_b", 32'(bus.in_ready), 32'h1);
      cycle();
      chk("bp_data0", 32'(bus.out_data0), 32'h2);
      chk("bp_data3", 32'(bus.out_data3), 32'hC);
      drive(1'b0, 2'd0, 4'h0, 4'b1111);
      cycle();
      cycle();

      // Pass-through on channel 2
      drive(1'b1, 2'd2, 4'h7, 4'b0000);
      cycle();
      drive(1'b1, 2'd2, 4'h9, 4'b0100);
      #1;
      chk("pt_in_ready", 32'(bus.in_ready), 32'h1);
      cycle();
      chk("pt_valid2", 32'(bus.out_valid[2]), 32'h1);
      chk("pt_data2",  32'(bus.out_data2),    32'h9);
      drive(1'b0, 2'd0, 4'h0, 4'b1111);
      cycle();

      // Asynchronous reset mid-run with channel 2 holding 0xA
      drive(1'b1, 2'd2, 4'hA, 4'b0000);
      cycle();
      chk("mr_pre_data2", 32'(bus.out_data2), 32'hA);
      drive(1'b0, 2'd2, 4'h0, 4'b0000);
      rst_n = 1'b0;
      #1;
      chk("mr_out_valid", 32'(bus.out_valid), 32'h0);
      chk("mr_data2",     32'(bus.out_data2), 32'h0);
      chk("mr_cnt2",      32'(xfer_cnt2),     32'h0);
      chk("mr_in_ready",  32'(bus.in_ready),  32'h1);
      model_clear();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Round-robin stream, all consumers ready
      for (int k = 0; k < 16; k++) begin
         drive(1'b1, ch_sel_t'(k % 4), W'(k), 4'b1111);
         cycle();
      end
      drive(1'b0, 2'd0, 4'h0, 4'b1111);
      cycle();
      cycle();
      for (int i = 0; i < N_CH; i++) chk($sformatf("rr_cnt%0d", i), 32'(oc(i)), 32'd4);

      // Counter wrap on channel 0
      pulse_reset();
      for (int k = 0; k < 256; k++) begin
         drive(1'b1, 2'd0, W'(k), 4'b1111);
         cycle();
         if (k == 254) chk("wrap_cnt0_255", 32'(xfer_cnt0), 32'd255);
      end
      chk("wrap_cnt0_0", 32'(xfer_cnt0), 32'd0);
      chk("wrap_cnt1",   32'(xfer_cnt1), 32'd0);
      chk("wrap_cnt2",   32'(xfer_cnt2), 32'd0);
      chk("wrap_cnt3",   32'(xfer_cnt3), 32'd0);
      drive(1'b0, 2'd0, 4'h0, 4'b1111);
      cycle();
      cycle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
